psum_gb_wr_arbiter: RTL
=======================

# psum_gb_wr_arbiter

Round-robin arbiter that merges the three PEB partial-sum output channels (PSUMGB_val/data/rdy 0..2, 16 x 32-bit lanes each) onto the single global-buffer write port. Per channel it generates the write address as base + beat count. It sequences one layer per configuration load and signals completion once every channel has delivered its programmed beat count. It sits between inst_PEB and the PSUM global buffer, and owns the GBPSUM_rdy0..2 handshakes.

## Interface
- DATA_WIDTH, 512, PSUM beat width (16 lanes x 32 b)
- ADDR_WIDTH, 12, GB word address width
- LEN_WIDTH, 16, per-channel beat-count width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_load  in  1  start pulse; latches cfg_base*/cfg_len when IDLE
- cfg_base0/1/2  in  ADDR_WIDTH each  start address per channel
- cfg_len  in  LEN_WIDTH  beats expected per channel
- PSUMGB_val0/1/2  in  1 each  channel beat valid
- PSUMGB_data0/1/2  in  DATA_WIDTH each  channel beat data
- GBPSUM_rdy0/1/2  out  1 each  channel beat accepted
- GB_wr_val  out  1  write request to GB
- GB_wr_data  out  DATA_WIDTH  write data
- GB_wr_addr  out  ADDR_WIDTH  write address
- GB_wr_ch  out  2  source channel (0..2)
- GB_wr_rdy  in  1  GB accepts write
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at layer completion

## Operation
- FSM: IDLE -> RUN on cfg_load; RUN -> DONE when cnt0 = cnt1 = cnt2 = len and the output register is empty; DONE -> IDLE unconditionally (done = 1 for that single cycle).
- IDLE + cfg_load: latch base0..2 and len, clear cnt0..2, clear the output register, set the RR pointer to ch0. cfg_load in RUN or DONE is ignored.
- len = 0: RUN lasts one cycle, then DONE with no writes.
- Eligible channel i: PSUMGB_val_i && cnt_i < len. A channel that has reached len is never granted. Its rdy stays 0 even if val is asserted.
- Grant: the first eligible channel starting at the pointer, in order ptr, ptr+1, ptr+2 mod 3. At most one grant per cycle.
- Accept condition: state == RUN && grant_i && (!GB_wr_val || GB_wr_rdy). GBPSUM_rdy_i equals the accept condition; it is combinational from the val inputs and the register state.
- On accept of ch i:
  - output register <= {data_i, addr = base_i + cnt_i (mod 2^ADDR_WIDTH, wrap silently), ch = i}
  - cnt_i++
  - ptr <= (i+1) mod 3
- With no accept, the pointer holds.
- Output register: single entry. GB_wr_val is set on accept. It clears on GB_wr_rdy when there is no simultaneous accept. Drain and refill in the same cycle is allowed (full throughput).
- Output data/addr/ch hold stable while GB_wr_val && !GB_wr_rdy.
- A reset mid-layer aborts: all state returns to its reset values, and in-flight data is dropped.

## Timing
- Reset values: GBPSUM_rdy0..2 = 0, GB_wr_val = 0, GB_wr_data = 0, GB_wr_addr = 0, GB_wr_ch = 0, busy = 0, done = 0, FSM = IDLE, ptr = 0, cnt = 0.
- Latency: a beat accepted at edge t appears on GB_wr_* in the cycle after t.
- Throughput: 1 beat/cycle aggregate while GB_wr_rdy = 1.
- busy rises the cycle after cfg_load. done pulses exactly one cycle after the last GB write handshake completes. busy = 0 during the DONE cycle.

## Configuration
- PSUM_ARB_STAT_EN defined: adds outputs stall_cnt0/1/2 (32 b each).
  - stall_cnt_i increments every RUN cycle with PSUMGB_val_i && !GBPSUM_rdy_i, saturating at 2^32-1.
  - Counters clear on cfg_load accepted in IDLE and on reset.
- PSUM_ARB_STAT_EN undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Test plan
- base0/1/2 = 0/64/128, len = 4, all val = 1, GB_wr_rdy = 1 -> grant order ch0,1,2,0,1,2,...; addresses 0,64,128,1,65,129,...; 12 writes in 12 consecutive cycles; done one cycle after the 12th write.
- Same config, only ch1 valid for 6 cycles -> exactly 4 beats accepted (addr 64..67); GBPSUM_rdy1 = 0 after the 4th; no done until ch0/ch2 finish.
- GB_wr_rdy = 0 for 5 cycles with an entry held -> all GBPSUM_rdy = 0; GB_wr_data/addr stable; the write completes when rdy returns; with PSUM_ARB_STAT_EN each valid channel's stall_cnt = 5.
- base2 = 4094, len = 4 -> ch2 addresses 4094, 4095, 0, 1 (wrap).
- len = 0, cfg_load -> busy for 1 cycle, done pulse, no GB_wr_val.
- Assert rst after 3 of 12 beats -> all outputs 0 immediately; a new cfg_load restarts counts from base with ptr = 0; cfg_load issued mid-RUN is ignored (addresses unchanged).

Source files
------------

// File: rtl/psum_gb_wr_arbiter.sv
// Round-robin merge of the three PEB psum channels onto the single PSUM GB write port.
// Optional stall counters are built when PSUM_ARB_STAT_EN is defined.

module psum_gb_wr_ch #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  acc,
  input  logic                  val,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  elig,
  output logic                  fin,
  output logic [ADDR_WIDTH-1:0] addr
);
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      cnt  <= '0;
    end else if (load) begin
      base <= base_in;
      cnt  <= '0;
    end else if (acc) begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign fin  = (cnt == len);
  assign elig = val && (cnt < len);
  // Address wraps silently at the top of the GB.
  assign addr = base + ADDR_WIDTH'(cnt);
endmodule

module psum_gb_wr_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [ADDR_WIDTH-1:0] cfg_base0,
  input  logic [ADDR_WIDTH-1:0] cfg_base1,
  input  logic [ADDR_WIDTH-1:0] cfg_base2,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  PSUMGB_val0,
  input  logic                  PSUMGB_val1,
  input  logic                  PSUMGB_val2,
  input  logic [DATA_WIDTH-1:0] PSUMGB_data0,
  input  logic [DATA_WIDTH-1:0] PSUMGB_data1,
  input  logic [DATA_WIDTH-1:0] PSUMGB_data2,
  output logic                  GBPSUM_rdy0,
  output logic                  GBPSUM_rdy1,
  output logic                  GBPSUM_rdy2,
  output logic                  GB_wr_val,
  output logic [DATA_WIDTH-1:0] GB_wr_data,
  output logic [ADDR_WIDTH-1:0] GB_wr_addr,
  output logic [1:0]            GB_wr_ch,
  input  logic                  GB_wr_rdy,
  output logic                  busy,
  output logic                  done
`ifdef PSUM_ARB_STAT_EN
  ,
  output logic [31:0]           stall_cnt0,
  output logic [31:0]           stall_cnt1,
  output logic [31:0]           stall_cnt2
`endif
);
  localparam int NCH = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0]                 len;
  logic [1:0]                           ptr, gidx;
  logic [NCH-1:0]                       val, elig, fin, gnt, acc;
  logic [NCH-1:0][ADDR_WIDTH-1:0]       base_in, addr;
  logic [NCH-1:0][DATA_WIDTH-1:0]       data;
  logic                                 load, any_gnt, slot_free, accept;

  assign val     = {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0};
  assign data    = {PSUMGB_data2, PSUMGB_data1, PSUMGB_data0};
  assign base_in = {cfg_base2, cfg_base1, cfg_base0};
  assign load    = (state == IDLE) && cfg_load;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    psum_gb_wr_ch #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_ch (
      .clk(clk), .rst(rst), .load(load), .acc(acc[i]), .val(val[i]),
      .base_in(base_in[i]), .len(len), .elig(elig[i]), .fin(fin[i]), .addr(addr[i])
    );
  end

  // First eligible channel scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    int c;
    gnt     = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    c       = 0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!any_gnt && elig[c]) begin
        gnt[c]  = 1'b1;
        gidx    = 2'(c);
        any_gnt = 1'b1;
      end
    end
  end

  assign slot_free = !GB_wr_val || GB_wr_rdy;
  assign accept    = (state == RUN) && any_gnt && slot_free;
  assign acc       = accept ? gnt : '0;
  assign {GBPSUM_rdy2, GBPSUM_rdy1, GBPSUM_rdy0} = acc;

  // Single-entry output register; drain and refill may happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      GB_wr_val  <= 1'b0;
      GB_wr_data <= '0;
      GB_wr_addr <= '0;
      GB_wr_ch   <= '0;
    end else if (load) begin
      GB_wr_val  <= 1'b0;
      GB_wr_data <= '0;
      GB_wr_addr <= '0;
      GB_wr_ch   <= '0;
    end else if (accept) begin
      GB_wr_val  <= 1'b1;
      GB_wr_data <= data[gidx];
      GB_wr_addr <= addr[gidx];
      GB_wr_ch   <= gidx;
    end else if (GB_wr_rdy) begin
      GB_wr_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      len <= '0;
    end else if (load) begin
      ptr <= '0;
      len <= cfg_len;
    end else if (accept) begin
      ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_load) state_nxt = RUN;
      RUN:     if (&fin && !GB_wr_val) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef PSUM_ARB_STAT_EN
  logic [NCH-1:0][31:0] stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall <= '0;
    end else if (load) begin
      stall <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCH; i++)
        if (val[i] && !acc[i] && stall[i] != 32'hFFFF_FFFF) stall[i] <= stall[i] + 32'd1;
    end
  end

  assign stall_cnt0 = stall[0];
  assign stall_cnt1 = stall[1];
  assign stall_cnt2 = stall[2];
`endif
endmodule
